wb_result_stage: RTL and testbench

WB_RESULT_STAGE -- requirements
Module: wb_result_stage

---
 rtl/wb_result_stage.sv | 182 ++++++++++++++++++
 tb/tb_wb_result_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_result_stage
// Brief    : Writeback result stage. It selects the result source, holds the
//            entry until the register file / commit accepts it, and counts
//            retired entries. Define WB_SKID_BUF_EN to add a skid entry so
//            that in_ready is a flop output.
// Revision : 1.0 - initial release
// ============================================================================
module wb_result_stage #(
    parameter int CNT_W    = 32,
    parameter int WB_SEL_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         alu_res,
    input  logic [31:0]         mem_rdata,
    input  logic [31:0]         pc,
    input  logic [31:0]         imm,
    input  logic [WB_SEL_W-1:0] wb_sel,
    input  logic [4:0]          rd,
    input  logic                reg_wen,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                rf_wen,
    output logic [CNT_W-1:0]    retire_cnt
);

    localparam logic [WB_SEL_W-1:0] c_SEL_MEM = WB_SEL_W'(1);
    localparam logic [WB_SEL_W-1:0] c_SEL_PC4 = WB_SEL_W'(2);
    localparam logic [WB_SEL_W-1:0] c_SEL_IMM = WB_SEL_W'(3);
    localparam logic [31:0]         c_PC_INC  = 32'd4;
    localparam logic [CNT_W-1:0]    c_CNT_ONE = CNT_W'(1);

    logic [31:0]      w_sel_data;
    logic             w_in_fire;
    logic             w_out_fire;

    logic             r_main_valid_q;
    logic [4:0]       r_main_rd_q;
    logic             r_main_wen_q;
    logic [31:0]      r_main_data_q;
    logic             w_main_valid_d;
    logic [4:0]       w_main_rd_d;
    logic             w_main_wen_d;
    logic [31:0]      w_main_data_d;

    logic [CNT_W-1:0] r_retire_cnt_q;
    logic [CNT_W-1:0] w_retire_cnt_d;

    always_comb begin
        w_sel_data = alu_res;
        case (wb_sel)
            c_SEL_MEM: w_sel_data = mem_rdata;
            c_SEL_PC4: w_sel_data = pc + c_PC_INC;
            c_SEL_IMM: w_sel_data = imm;
            default:   w_sel_data = alu_res;
        endcase
    end

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_main_valid_q & out_ready;

`ifdef WB_SKID_BUF_EN
    logic             r_skid_valid_q;
    logic [4:0]       r_skid_rd_q;
    logic             r_skid_wen_q;
    logic [31:0]      r_skid_data_q;
    logic             w_skid_valid_d;
    logic [4:0]       w_skid_rd_d;
    logic             w_skid_wen_d;
    logic [31:0]      w_skid_data_d;
    logic             r_in_ready_q;
    logic             w_in_ready_d;

    // in_ready is low whenever the skid entry is occupied, so an input fire
    // never coincides with a skid-to-main transfer.
    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_rd_d    = r_main_rd_q;
        w_main_wen_d   = r_main_wen_q;
        w_main_data_d  = r_main_data_q;
        w_skid_valid_d = r_skid_valid_q;
        w_skid_rd_d    = r_skid_rd_q;
        w_skid_wen_d   = r_skid_wen_q;
        w_skid_data_d  = r_skid_data_q;
        if (w_out_fire && r_skid_valid_q) begin
            w_main_valid_d = 1'b1;
            w_main_rd_d    = r_skid_rd_q;
            w_main_wen_d   = r_skid_wen_q;
            w_main_data_d  = r_skid_data_q;
            w_skid_valid_d = 1'b0;
        end else if (w_in_fire) begin
            if (!r_main_valid_q || w_out_fire) begin
                w_main_valid_d = 1'b1;
                w_main_rd_d    = rd;
                w_main_wen_d   = reg_wen;
                w_main_data_d  = w_sel_data;
            end else begin
                w_skid_valid_d = 1'b1;
                w_skid_rd_d    = rd;
                w_skid_wen_d   = reg_wen;
                w_skid_data_d  = w_sel_data;
            end
        end else if (w_out_fire) begin
            w_main_valid_d = 1'b0;
        end
        w_in_ready_d = ~w_skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_skid_valid_q <= 1'b0;
            r_skid_rd_q    <= 5'd0;
            r_skid_wen_q   <= 1'b0;
            r_skid_data_q  <= 32'd0;
            r_in_ready_q   <= 1'b1;
        end else begin
            r_skid_valid_q <= w_skid_valid_d;
            r_skid_rd_q    <= w_skid_rd_d;
            r_skid_wen_q   <= w_skid_wen_d;
            r_skid_data_q  <= w_skid_data_d;
            r_in_ready_q   <= w_in_ready_d;
        end
    end

    assign in_ready = r_in_ready_q;
`else
    always_comb begin
        w_main_valid_d = r_main_valid_q;
        w_main_rd_d    = r_main_rd_q;
        w_main_wen_d   = r_main_wen_q;
        w_main_data_d  = r_main_data_q;
        if (w_in_fire) begin
            w_main_valid_d = 1'b1;
            w_main_rd_d    = rd;
            w_main_wen_d   = reg_wen;
            w_main_data_d  = w_sel_data;
        end else if (w_out_fire) begin
            w_main_valid_d = 1'b0;
        end
    end

    assign in_ready = ~r_main_valid_q | out_ready;
`endif

    always_comb begin
        w_retire_cnt_d = r_retire_cnt_q;
        if (w_out_fire) begin
            w_retire_cnt_d = r_retire_cnt_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_valid_q <= 1'b0;
            r_main_rd_q    <= 5'd0;
            r_main_wen_q   <= 1'b0;
            r_main_data_q  <= 32'd0;
            r_retire_cnt_q <= '0;
        end else begin
            r_main_valid_q <= w_main_valid_d;
            r_main_rd_q    <= w_main_rd_d;
            r_main_wen_q   <= w_main_wen_d;
            r_main_data_q  <= w_main_data_d;
            r_retire_cnt_q <= w_retire_cnt_d;
        end
    end

    // x0 is hard-wired zero, so writes to it are suppressed at the strobe.
    assign out_valid  = r_main_valid_q;
    assign rf_waddr   = r_main_rd_q;
    assign rf_wdata   = r_main_data_q;
    assign rf_wen     = w_out_fire & r_main_wen_q & (r_main_rd_q != 5'd0);
    assign retire_cnt = r_retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_result_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_result_stage
// Brief    : Self-checking bench for wb_result_stage against a queue-based
//            reference model (default and 4-bit counter instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_result_stage;

`ifdef WB_SKID_BUF_EN
    localparam bit c_SKID = 1'b1;
`else
    localparam bit c_SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        reg_wen;
    logic [31:0] alu_res;
    logic [31:0] mem_rdata;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [1:0]  wb_sel;
    logic [4:0]  rd;

    logic        in_ready;
    logic        out_valid;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] retire_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic        rf_wen4;
    logic [4:0]  rf_waddr4;
    logic [31:0] rf_wdata4;
    logic [3:0]  retire_cnt4;

    typedef struct packed {
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned model_cnt;
    int          n_checks;
    int          n_errors;

    always #5 clk = ~clk;

    wb_result_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_res(alu_res), .mem_rdata(mem_rdata), .pc(pc), .imm(imm),
        .wb_sel(wb_sel), .rd(rd), .reg_wen(reg_wen), .out_valid(out_valid),
        .out_ready(out_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_wen(rf_wen), .retire_cnt(retire_cnt)
    );

    wb_result_stage #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .alu_res(alu_res), .mem_rdata(mem_rdata), .pc(pc), .imm(imm),
        .wb_sel(wb_sel), .rd(rd), .reg_wen(reg_wen), .out_valid(out_valid4),
        .out_ready(out_ready), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .rf_wen(rf_wen4), .retire_cnt(retire_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sel_data(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] m, input logic [31:0] p,
                                             input logic [31:0] i);
        case (sel)
            2'd0:    return a;
            2'd1:    return m;
            2'd2:    return p + 32'd4;
            default: return i;
        endcase
    endfunction

    // One clock cycle: drive at negedge, check against the model, advance the model at posedge.
    task automatic do_cycle(input logic iv, input logic ordy, input logic [1:0] sel,
                            input logic [4:0] r, input logic w, input logic [31:0] a,
                            input logic [31:0] m, input logic [31:0] p, input logic [31:0] i);
        logic exp_ready;
        logic exp_wen;
        logic in_fire;
        logic out_fire;
        ent_t e;
        @(negedge clk);
        in_valid = iv; out_ready = ordy; wb_sel = sel; rd = r; reg_wen = w;
        alu_res = a; mem_rdata = m; pc = p; imm = i;
        #1;
        exp_ready = c_SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
        chk("in_ready", in_ready, exp_ready);
        chk("in_ready4", in_ready4, exp_ready);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_valid4", out_valid4, q.size() != 0);
        if (q.size() != 0) begin
            exp_wen = ordy && q[0].wen && (q[0].rd != 5'd0);
            chk("rf_waddr", rf_waddr, q[0].rd);
            chk("rf_wdata", rf_wdata, q[0].data);
            chk("rf_wdata4", rf_wdata4, q[0].data);
            chk("rf_wen", rf_wen, exp_wen);
            chk("rf_wen4", rf_wen4, exp_wen);
        end else begin
            chk("rf_wen_idle", rf_wen, 1'b0);
        end
        chk("retire_cnt", retire_cnt, model_cnt);
        chk("retire_cnt4", retire_cnt4, model_cnt % 16);
        in_fire  = iv && exp_ready;
        out_fire = ordy && (q.size() != 0);
        @(posedge clk);
        if (out_fire) begin
            void'(q.pop_front());
            model_cnt++;
        end
        if (in_fire) begin
            e.rd   = r;
            e.wen  = w;
            e.data = sel_data(sel, a, m, p, i);
            q.push_back(e);
        end
    endtask

    // Reset asserted partway through the low phase, checked before the next edge.
    task automatic reset_mid();
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_retire_cnt", retire_cnt, 32'd0);
        chk("rst_retire_cnt4", retire_cnt4, 4'd0);
        chk("rst_rf_waddr", rf_waddr, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        q.delete();
        model_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0; model_cnt = 0;
        in_valid = 0; out_ready = 0; reg_wen = 0; wb_sel = 0; rd = 0;
        alu_res = 0; mem_rdata = 0; pc = 0; imm = 0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("init_out_valid", out_valid, 1'b0);
        chk("init_rf_wen", rf_wen, 1'b0);
        chk("init_retire_cnt", retire_cnt, 32'd0);
        chk("init_rf_wdata", rf_wdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Source select, one per cycle with out_ready held high
        for (int s = 0; s < 4; s++)
            do_cycle(1, 1, 2'(s), 5'd5, 1, 32'h11, 32'h22, 32'h8000_0000, 32'h44);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("select_cnt", retire_cnt, 32'd4);
        chk("select_drained", out_valid, 1'b0);

        // x0 destination and PC+4 wraparound
        do_cycle(1, 1, 0, 5'd0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        do_cycle(1, 1, 2, 5'd7, 1, 0, 0, 32'hFFFF_FFFC, 0);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_cnt", retire_cnt, 32'd6);

        // Backpressure with continuous input
        repeat (5) do_cycle(1, 0, 2'($urandom_range(0, 3)), 5'($urandom_range(1, 31)), 1,
                            $urandom, $urandom, $urandom, $urandom);
        #1;
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        repeat (3) do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("bp_drained", out_valid, 1'b0);

        // Counter wrap on the 4-bit instance
        reset_mid();
        repeat (17) do_cycle(1, 1, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wrap_cnt4", retire_cnt4, 4'd1);
        chk("wrap_cnt32", retire_cnt, 32'd17);

        // Reset while entries are held
        repeat (3) do_cycle(1, 0, 0, 5'd9, 1, $urandom, 0, 0, 0);
        #1;
        chk("pre_rst_valid", out_valid, 1'b1);
        reset_mid();
        do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Random valid/ready traffic
        for (int k = 0; k < 10000; k++)
            do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                     2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, $urandom);
        repeat (3) do_cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
